logic_unit_pipe: RTL and testbench

LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

---
 rtl/logic_unit_pkg.sv | 18 +
 rtl/logic_unit_core.sv | 27 ++
 rtl/logic_unit_pipe.sv | 117 +++++++++++
 tb/tb_logic_unit_pipe.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared definitions for the logic unit pipeline: the op-code type, its
// eight encodings and the default operand width.
package logic_unit_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef logic [2:0] op_t;

  localparam op_t OP_NAND = 3'b000;
  localparam op_t OP_NOR  = 3'b001;
  localparam op_t OP_AND  = 3'b010;
  localparam op_t OP_OR   = 3'b011;
  localparam op_t OP_XOR  = 3'b100;
  localparam op_t OP_XNOR = 3'b101;
  localparam op_t OP_NOTA = 3'b110;
  localparam op_t OP_PASS = 3'b111;

endpackage

// File: rtl/logic_unit_core.sv
// Purely combinational bitwise operator selected by a 3-bit op code.
import logic_unit_pkg::*;

module logic_unit_core #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = a;
    case (op)
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_XNOR: result = ~(a ^ b);
      OP_NOTA: result = ~a;
      default: result = a;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready pipeline around logic_unit_core with a delivered-result
// counter. Define LOGIC_UNIT_PIPE_PARITY_EN to add the registered out_parity port.
import logic_unit_pkg::*;

module logic_unit_pipe #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             out_zero,
  output logic [CNT_W-1:0] count
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  logic             v1_q, v1_d;
  logic [WIDTH-1:0] a1_q, a1_d, b1_q, b1_d;
  logic [2:0]       op1_q, op1_d;
  logic             v2_q, v2_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             zero_q, zero_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] result;
  logic             load2, in_xfer, out_xfer;

  logic_unit_core #(.WIDTH(WIDTH)) u_core (
    .a      (a1_q),
    .b      (b1_q),
    .op     (op1_q),
    .result (result)
  );

  // Stage 2 may take a new beat when empty or when its beat leaves this cycle.
  assign load2    = !v2_q || out_ready;
  assign in_ready = !v1_q || load2;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = v2_q && out_ready;

  always_comb begin
    v1_d    = v1_q;
    a1_d    = a1_q;
    b1_d    = b1_q;
    op1_d   = op1_q;
    v2_d    = v2_q;
    s_d     = s_q;
    zero_d  = zero_q;
    count_d = count_q;
    if (in_xfer) begin
      v1_d  = 1'b1;
      a1_d  = a;
      b1_d  = b;
      op1_d = op;
    end else if (load2) begin
      v1_d = 1'b0;
    end
    // Result fields only change when a real beat arrives, so s stays stable
    // after the last beat drains.
    if (load2) begin
      v2_d = v1_q;
      if (v1_q) begin
        s_d    = result;
        zero_d = (result == '0);
      end
    end
    if (out_xfer) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q    <= 1'b0;
      a1_q    <= '0;
      b1_q    <= '0;
      op1_q   <= '0;
      v2_q    <= 1'b0;
      s_q     <= '0;
      zero_q  <= 1'b0;
      count_q <= '0;
    end else begin
      v1_q    <= v1_d;
      a1_q    <= a1_d;
      b1_q    <= b1_d;
      op1_q   <= op1_d;
      v2_q    <= v2_d;
      s_q     <= s_d;
      zero_q  <= zero_d;
      count_q <= count_d;
    end
  end

`ifdef LOGIC_UNIT_PIPE_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              parity_q <= 1'b0;
    else if (load2 && v1_q) parity_q <= ^result;
  end

  assign out_parity = parity_q;
`endif

  assign out_valid = v2_q;
  assign s         = s_q;
  assign out_zero  = zero_q;
  assign count     = count_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe (WIDTH=8, CNT_W=4): truth table, zero
// flag, stall/backpressure, counter wrap, parity (when built with it) and reset.
`timescale 1ns/1ps

module tb_logic_unit_pipe;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [2:0] op = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] s;
  logic       out_zero;
  logic [3:0] count;
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
  logic       out_parity;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .out_zero  (out_zero),
    .count     (count)
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated beat; result checked two edges after the beat is offered.
  task automatic run_vec(input logic [7:0] va, input logic [7:0] vb, input logic [2:0] vop,
                         input logic [7:0] exp_s, input logic exp_z, input logic exp_p);
    a = va; b = vb; op = vop; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check($sformatf("vec op=%0d valid", vop), out_valid, 1'b1);
    check($sformatf("vec op=%0d s", vop), s, exp_s);
    check($sformatf("vec op=%0d zero", vop), out_zero, exp_z);
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
    check($sformatf("vec op=%0d parity", vop), out_parity, exp_p);
`else
    if (exp_p === 1'bx) $display("note: parity port not built");
`endif
  endtask

  logic [7:0] tt_exp [8] = '{8'h3F, 8'h03, 8'hC0, 8'hFC, 8'h3C, 8'hC3, 8'h0F, 8'hF0};

  initial begin
    // Reset state
    tick();
    tick();
    check("rst out_valid", out_valid, 1'b0);
    check("rst s", s, 8'h00);
    check("rst out_zero", out_zero, 1'b0);
    check("rst count", count, 4'd0);
    reset = 1'b0;
    #1;
    check("rst in_ready", in_ready, 1'b1);
    tick();

    // Truth table, back to back at full throughput
    out_ready = 1'b1;
    a = 8'hF0; b = 8'hCC;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        in_valid = 1'b1;
        op = 3'(i);
        check($sformatf("tt in_ready %0d", i), in_ready, 1'b1);
      end else begin
        in_valid = 1'b0;
      end
      if (i >= 2) begin
        check($sformatf("tt valid op%0d", i - 2), out_valid, 1'b1);
        check($sformatf("tt s op%0d", i - 2), s, tt_exp[i-2]);
        check($sformatf("tt zero op%0d", i - 2), out_zero, 1'b0);
      end
      tick();
    end
    check("tt drained", out_valid, 1'b0);
    check("tt count", count, 4'd8);

    // Zero flag and b-independence of NOT a / pass a
    run_vec(8'hFF, 8'hFF, 3'b000, 8'h00, 1'b1, 1'b0);
    run_vec(8'hFF, 8'hFF, 3'b011, 8'hFF, 1'b0, 1'b0);
    run_vec(8'hF0, 8'h00, 3'b110, 8'h0F, 1'b0, 1'b0);
    run_vec(8'h5A, 8'hFF, 3'b111, 8'h5A, 1'b0, 1'b0);
    tick();
    check("vec count", count, 4'd12);

    // Stall: three beats offered while downstream is blocked
    out_ready = 1'b0;
    a = 8'h12; b = 8'h34;
    op = 3'b010; in_valid = 1'b1;
    check("stall acc A", in_ready, 1'b1);
    tick();
    op = 3'b011;
    check("stall acc B", in_ready, 1'b1);
    tick();
    op = 3'b100;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stall in_ready %0d", i), in_ready, 1'b0);
      check($sformatf("stall valid %0d", i), out_valid, 1'b1);
      check($sformatf("stall s %0d", i), s, 8'h10);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("stall release in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check("stall s B", s, 8'h36);
    tick();
    check("stall s C", s, 8'h26);
    check("stall valid C", out_valid, 1'b1);
    tick();
    check("stall drained", out_valid, 1'b0);
    check("stall count", count, 4'd15);

    // Counter wrap (17 deliveries) and parity
    run_vec(8'h07, 8'h00, 3'b111, 8'h07, 1'b0, 1'b1);
    run_vec(8'h00, 8'hAA, 3'b111, 8'h00, 1'b1, 1'b0);
    tick();
    check("wrap count", count, 4'd1);

    // Reset with two beats in flight
    out_ready = 1'b0;
    a = 8'h55; b = 8'h0F; op = 3'b010; in_valid = 1'b1;
    tick();
    op = 3'b100;
    tick();
    check("mid inflight valid", out_valid, 1'b1);
    reset = 1'b1;
    #1;
    check("mid rst out_valid", out_valid, 1'b0);
    check("mid rst count", count, 4'd0);
    check("mid rst s", s, 8'h00);
    a = 8'h3C; b = 8'h0F; op = 3'b001; in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("post rst in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check("post rst no stale", out_valid, 1'b0);
    tick();
    check("post rst valid D", out_valid, 1'b1);
    check("post rst s D", s, 8'hC0);
    tick();
    check("post rst drained", out_valid, 1'b0);
    check("post rst count", count, 4'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
